// File: rtl/mest_pro_fetch_unit.sv
// MESTPro instruction fetch stage: owns the PC and the instruction memory read port,
// holds the current instruction for decode/execute and reports end-of-code.
module mest_pro_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 16,
  parameter int OPCODE_W = 4,
  parameter logic [OPCODE_W-1:0] EOC_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               i_reset_n,
  input  logic               i_idle,
  input  logic               i_start,
  input  logic [ADDR_W-1:0]  i_start_addr,
  input  logic               i_fetch,
  input  logic               i_execute,
  input  logic               i_branch_en,
  input  logic [ADDR_W-1:0]  i_branch_addr,
  output logic               o_imem_rd_en,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instr_valid,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_end_of_code,
  output logic               o_fetch_err
);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_HOLD = 2'd2
  } fstate_t;

  fstate_t              state_r, state_s;
  logic [ADDR_W-1:0]    pc_r, pc_s;
  logic [INSTR_W-1:0]   ir_r, ir_s;
  logic                 ovf_r, ovf_s;
  logic                 err_r, err_s;
  logic                 start_s;
  logic [INSTR_W-1:0]   instr_s;
  logic                 valid_s;

  // State, PC, IR and sticky flags register
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= F_IDLE;
      pc_r    <= '0;
      ir_r    <= '0;
      ovf_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      ir_r    <= ir_s;
      ovf_r   <= ovf_s;
      err_r   <= err_s;
    end
  end

  // Next-state logic: start beats fetch, fetch beats branch
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    ir_s    = ir_r;
    ovf_s   = ovf_r;
    err_s   = err_r;
    start_s = i_start & i_idle;

    if (start_s) begin
      pc_s    = i_start_addr;
      ir_s    = '0;
      ovf_s   = 1'b0;
      err_s   = 1'b0;
      state_s = F_IDLE;
    end else begin
      // Whatever arrives while waiting is latched, including the re-read after a protocol error
      if (state_r == F_WAIT) begin
        ir_s = i_imem_rdata;
      end else begin
        ir_s = ir_r;
      end

      if (i_fetch) begin
        pc_s    = pc_r + ADDR_W'(1);
        state_s = F_WAIT;
        if (pc_r == {ADDR_W{1'b1}}) begin
          ovf_s = 1'b1;
        end else begin
          ovf_s = ovf_r;
        end
        if (state_r == F_WAIT) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
      end else begin
        if (i_execute && i_branch_en) begin
          pc_s = i_branch_addr;
        end else begin
          pc_s = pc_r;
        end
        case (state_r)
          F_IDLE:  state_s = F_IDLE;
          F_WAIT:  state_s = F_HOLD;
          F_HOLD:  state_s = F_HOLD;
          default: state_s = F_IDLE;
        endcase
      end
    end
  end

  // Instruction output mux: forward read data while waiting, IR once held
  always_comb begin
    instr_s = '0;
    valid_s = 1'b0;
    case (state_r)
      F_WAIT: begin
        instr_s = i_imem_rdata;
        valid_s = 1'b1;
      end
      F_HOLD: begin
        instr_s = ir_r;
        valid_s = 1'b1;
      end
      default: begin
        instr_s = '0;
        valid_s = 1'b0;
      end
    endcase
  end

  assign o_imem_rd_en  = i_fetch;
  assign o_imem_addr   = pc_r;
  assign o_pc          = pc_r;
  assign o_instr       = instr_s;
  assign o_instr_valid = valid_s;
  assign o_fetch_err   = err_r;
  assign o_end_of_code = (valid_s & (instr_s[INSTR_W-1 -: OPCODE_W] == EOC_OPCODE)) | ovf_r;

endmodule

// File: tb/tb_mest_pro_fetch_unit.sv
// Self-checking bench for mest_pro_fetch_unit: models the controller strobes and a
// synchronous instruction RAM, scoreboarding fetched instructions against DECODE/EXECUTE.
module tb_mest_pro_fetch_unit;

  logic        clk = 1'b0;
  logic        i_reset_n, i_idle, i_start, i_fetch, i_execute, i_branch_en;
  logic [7:0]  i_start_addr, i_branch_addr, o_imem_addr, o_pc;
  logic [15:0] i_imem_rdata = 16'h0000;
  logic [15:0] o_instr;
  logic        o_imem_rd_en, o_instr_valid, o_end_of_code, o_fetch_err;

  logic [15:0] mem [256];
  logic [15:0] exp_q [$];
  logic [7:0]  exp_pc;
  logic        exp_ovf;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mest_pro_fetch_unit dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_idle(i_idle), .i_start(i_start),
    .i_start_addr(i_start_addr), .i_fetch(i_fetch), .i_execute(i_execute),
    .i_branch_en(i_branch_en), .i_branch_addr(i_branch_addr),
    .o_imem_rd_en(o_imem_rd_en), .o_imem_addr(o_imem_addr), .i_imem_rdata(i_imem_rdata),
    .o_instr(o_instr), .o_instr_valid(o_instr_valid), .o_pc(o_pc),
    .o_end_of_code(o_end_of_code), .o_fetch_err(o_fetch_err)
  );

  // Synchronous RAM: data one cycle after the strobe
  always @(posedge clk) begin
    if (o_imem_rd_en) i_imem_rdata <= mem[o_imem_addr];
  end

  task automatic do_start(input logic [7:0] a);
    @(negedge clk);
    i_idle = 1'b1; i_start = 1'b1; i_start_addr = a;
    @(negedge clk);
    i_idle = 1'b0; i_start = 1'b0;
    exp_pc = a; exp_ovf = 1'b0; exp_q.delete();
    #1;
  endtask

  // One FETCH/DECODE/EXECUTE loop; optional branch request in DECODE (ignored) or EXECUTE
  task automatic run_loop(input logic br_exec, input logic br_dec, input logic [7:0] tgt);
    logic [15:0] exp;
    logic        exp_eoc;
    i_fetch = 1'b1; #1;
    n_cmp++; if (o_imem_rd_en !== 1'b1) begin n_bad++; $display("FAIL fetch_rd_en: got %b want 1", o_imem_rd_en); end
    n_cmp++; if (o_imem_addr !== exp_pc) begin n_bad++; $display("FAIL fetch_addr: got %h want %h", o_imem_addr, exp_pc); end
    exp_q.push_back(mem[exp_pc]);
    if (exp_pc == 8'hFF) exp_ovf = 1'b1;
    exp_pc = exp_pc + 8'd1;
    @(negedge clk);
    i_fetch = 1'b0; i_branch_en = br_dec; i_branch_addr = tgt; #1;
    exp = exp_q.pop_front();
    exp_eoc = (exp[15:12] == 4'hF) | exp_ovf;
    n_cmp++; if (o_instr !== exp) begin n_bad++; $display("FAIL decode_instr: got %h want %h", o_instr, exp); end
    n_cmp++; if (o_instr_valid !== 1'b1) begin n_bad++; $display("FAIL decode_valid: got %b want 1", o_instr_valid); end
    n_cmp++; if (o_pc !== exp_pc) begin n_bad++; $display("FAIL decode_pc: got %h want %h", o_pc, exp_pc); end
    n_cmp++; if (o_end_of_code !== exp_eoc) begin n_bad++; $display("FAIL decode_eoc: got %b want %b", o_end_of_code, exp_eoc); end
    @(negedge clk);
    i_branch_en = br_exec; i_execute = 1'b1; #1;
    n_cmp++; if (o_instr !== exp) begin n_bad++; $display("FAIL exec_instr: got %h want %h", o_instr, exp); end
    n_cmp++; if (o_pc !== exp_pc) begin n_bad++; $display("FAIL exec_pc: got %h want %h", o_pc, exp_pc); end
    n_cmp++; if (o_end_of_code !== exp_eoc) begin n_bad++; $display("FAIL exec_eoc: got %b want %b", o_end_of_code, exp_eoc); end
    if (br_exec) exp_pc = tgt;
    @(negedge clk);
    i_execute = 1'b0; i_branch_en = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; i_idle = 1'b0; i_start = 1'b0; i_fetch = 1'b0; i_execute = 1'b0;
    i_branch_en = 1'b0; i_start_addr = 8'h00; i_branch_addr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (o_pc !== 8'h00) begin n_bad++; $display("FAIL reset_pc: got %h want 00", o_pc); end
    n_cmp++; if (o_instr !== 16'h0000) begin n_bad++; $display("FAIL reset_instr: got %h want 0000", o_instr); end
    n_cmp++; if ({o_imem_rd_en, o_imem_addr, o_instr_valid, o_end_of_code, o_fetch_err} !== 12'h000)
      begin n_bad++; $display("FAIL reset_outs: got %b%h%b%b%b want all 0", o_imem_rd_en, o_imem_addr, o_instr_valid, o_end_of_code, o_fetch_err); end
    @(negedge clk);
    i_reset_n = 1'b1;
  endtask

  task automatic test_start();
    do_start(8'h10);
    n_cmp++; if (o_pc !== 8'h10) begin n_bad++; $display("FAIL start_pc: got %h want 10", o_pc); end
    n_cmp++; if (o_instr_valid !== 1'b0) begin n_bad++; $display("FAIL start_valid: got %b want 0", o_instr_valid); end
    n_cmp++; if (o_instr !== 16'h0000) begin n_bad++; $display("FAIL start_instr: got %h want 0000", o_instr); end
    n_cmp++; if ({o_imem_rd_en, o_end_of_code, o_fetch_err} !== 3'b000)
      begin n_bad++; $display("FAIL start_flags: got %b%b%b want 000", o_imem_rd_en, o_end_of_code, o_fetch_err); end
  endtask

  task automatic test_straight_line();
    mem[8'h10] = 16'h1234; mem[8'h11] = 16'h2345; mem[8'h12] = 16'hF000;
    for (int i = 0; i < 3; i++) run_loop(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_branch();
    mem[8'h20] = 16'h3000; mem[8'h21] = 16'h5111; mem[8'h40] = 16'h4444;
    do_start(8'h20);
    run_loop(1'b0, 1'b1, 8'h55);
    run_loop(1'b1, 1'b0, 8'h40);
    run_loop(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_wrap();
    mem[8'hFF] = 16'h0001; mem[8'h00] = 16'h0777;
    do_start(8'hFF);
    run_loop(1'b0, 1'b0, 8'h00);
    run_loop(1'b1, 1'b0, 8'h05);
    n_cmp++; if (o_end_of_code !== 1'b1) begin n_bad++; $display("FAIL wrap_sticky_eoc: got %b want 1", o_end_of_code); end
    do_start(8'h10);
    n_cmp++; if (o_end_of_code !== 1'b0) begin n_bad++; $display("FAIL wrap_start_clear: got %b want 0", o_end_of_code); end
  endtask

  task automatic test_protocol_err();
    logic [15:0] exp;
    mem[8'h30] = 16'h1111; mem[8'h31] = 16'h2222;
    do_start(8'h30);
    i_fetch = 1'b1; #1;
    exp_q.push_back(mem[exp_pc]); exp_pc = exp_pc + 8'd1;
    @(negedge clk); #1;
    exp = exp_q.pop_front();
    n_cmp++; if (o_instr !== exp) begin n_bad++; $display("FAIL perr_first_instr: got %h want %h", o_instr, exp); end
    n_cmp++; if (o_imem_addr !== exp_pc) begin n_bad++; $display("FAIL perr_second_addr: got %h want %h", o_imem_addr, exp_pc); end
    n_cmp++; if (o_fetch_err !== 1'b0) begin n_bad++; $display("FAIL perr_not_yet: got %b want 0", o_fetch_err); end
    exp_q.push_back(mem[exp_pc]); exp_pc = exp_pc + 8'd1;
    @(negedge clk);
    i_fetch = 1'b0; #1;
    exp = exp_q.pop_front();
    n_cmp++; if (o_fetch_err !== 1'b1) begin n_bad++; $display("FAIL perr_set: got %b want 1", o_fetch_err); end
    n_cmp++; if (o_instr !== exp) begin n_bad++; $display("FAIL perr_second_fwd: got %h want %h", o_instr, exp); end
    @(negedge clk); #1;
    n_cmp++; if (o_instr !== exp) begin n_bad++; $display("FAIL perr_second_held: got %h want %h", o_instr, exp); end
    n_cmp++; if (o_pc !== exp_pc) begin n_bad++; $display("FAIL perr_pc: got %h want %h", o_pc, exp_pc); end
    @(negedge clk); #1;
    n_cmp++; if (o_fetch_err !== 1'b1) begin n_bad++; $display("FAIL perr_sticky: got %b want 1", o_fetch_err); end
    do_start(8'h30);
    n_cmp++; if (o_fetch_err !== 1'b0) begin n_bad++; $display("FAIL perr_start_clear: got %b want 0", o_fetch_err); end
  endtask

  task automatic test_async_reset();
    mem[8'h50] = 16'hA5A5; mem[8'h51] = 16'hB6B6;
    do_start(8'h50);
    i_fetch = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_fetch = 1'b0; #1;
    n_cmp++; if ({o_instr_valid, o_fetch_err} !== 2'b11) begin n_bad++; $display("FAIL areset_pre: got %b%b want 11", o_instr_valid, o_fetch_err); end
    #1 i_reset_n = 1'b0;
    #1;
    n_cmp++; if (o_pc !== 8'h00) begin n_bad++; $display("FAIL areset_pc: got %h want 00", o_pc); end
    n_cmp++; if (o_instr !== 16'h0000) begin n_bad++; $display("FAIL areset_instr: got %h want 0000", o_instr); end
    n_cmp++; if ({o_imem_addr, o_instr_valid, o_end_of_code, o_fetch_err} !== 11'h000)
      begin n_bad++; $display("FAIL areset_outs: got %h%b%b%b want all 0", o_imem_addr, o_instr_valid, o_end_of_code, o_fetch_err); end
    @(negedge clk);
    i_reset_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (o_pc !== 8'h00) begin n_bad++; $display("FAIL areset_release_pc: got %h want 00", o_pc); end
  endtask

  task automatic test_fetch_exec_overlap();
    do_start(8'h60);
    i_fetch = 1'b1; i_execute = 1'b1; i_branch_en = 1'b1; i_branch_addr = 8'h99;
    @(negedge clk);
    i_fetch = 1'b0; i_execute = 1'b0; i_branch_en = 1'b0; #1;
    n_cmp++; if (o_pc !== 8'h61) begin n_bad++; $display("FAIL overlap_pc: got %h want 61", o_pc); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_straight_line();
    test_branch();
    test_wrap();
    test_protocol_err();
    test_async_reset();
    test_fetch_exec_overlap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
